// File: rtl/uk101_autotype_seq.sv
// Scripted keystroke / system-reset sequencer for the UK101 core.
// Replays a parameter-stored script of timed key presses and reset pulses.
module uk101_autotype_seq #(
    parameter int unsigned          tick_div  = 8388608,
    parameter int unsigned          gap_ticks = 1,
    parameter int unsigned          n_keys    = 3,
    parameter int unsigned          n_steps   = 8,
    parameter logic [8*n_steps-1:0] script    = 64'hFFFFFF02_0201001D,
    parameter bit                   autostart = 1'b1,
    localparam int unsigned         step_w    = (n_steps > 1) ? $clog2(n_steps) : 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic              abort,
    output logic              sys_n_reset,
    output logic [n_keys-1:0] keys,
    output logic              busy,
    output logic              done,
    output logic [step_w-1:0] step_idx
);

    localparam int unsigned       pre_w     = $clog2(tick_div);
    localparam logic [pre_w-1:0]  pre_last  = pre_w'(tick_div - 1);
    localparam logic [4:0]        gap_last  = 5'(gap_ticks - 1);
    localparam logic [step_w-1:0] step_last = step_w'(n_steps - 1);
    localparam logic [3:0]        code_rst  = 4'hD;
    localparam logic [3:0]        code_end  = 4'hF;

    typedef enum logic [1:0] {StIdle, StPress, StGap, StDone} state_e;

    state_e              state_q, state_d;
    logic [pre_w-1:0]    pre_q, pre_d;
    logic [4:0]          tick_q, tick_d;
    logic [step_w-1:0]   step_q, step_d, load_idx;
    logic [3:0]          code_q, code_d, hold_q, hold_d;
    logic [7:0]          entry;
    logic                pending_q, pending_d, load, tick_wrap;
    logic [n_keys-1:0]   keys_q, keys_d;
    logic                snr_q, snr_d, busy_q, busy_d, done_q, done_d;

    assign tick_wrap = (pre_q == pre_last);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= StIdle;
            pre_q     <= '0;
            tick_q    <= '0;
            step_q    <= '0;
            code_q    <= '0;
            hold_q    <= '0;
            pending_q <= autostart;
            keys_q    <= '0;
            snr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            step_q    <= step_d;
            code_q    <= code_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            keys_q    <= keys_d;
            snr_q     <= snr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        code_d    = code_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        pre_d     = tick_wrap ? '0 : pre_q + pre_w'(1);
        tick_d    = tick_wrap ? tick_q + 5'd1 : tick_q;
        load      = 1'b0;
        load_idx  = '0;
        entry     = '0;
        unique case (state_q)
            StIdle: begin
                if (abort) begin
                    pending_d = 1'b0;
                end else if (start || pending_q) begin
                    load      = 1'b1;
                    pending_d = 1'b0;
                end
            end
            StPress: begin
                if (abort) begin
                    state_d = StIdle;
                    step_d  = '0;
                end else if (tick_wrap && tick_q == {1'b0, hold_q}) begin
                    state_d = StGap;
                    pre_d   = '0;
                    tick_d  = '0;
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                    step_d  = '0;
                end else if (tick_wrap && tick_q == gap_last) begin
                    if (step_q == step_last) begin
                        state_d = StDone;
                    end else begin
                        load     = 1'b1;
                        load_idx = step_q + step_w'(1);
                    end
                end
            end
            StDone: begin
                if (abort) begin
                    state_d = StIdle;
                    step_d  = '0;
                end else if (start) begin
                    load = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            entry   = script[{load_idx, 3'b000} +: 8];
            step_d  = load_idx;
            code_d  = entry[3:0];
            hold_d  = entry[7:4];
            pre_d   = '0;
            tick_d  = '0;
            state_d = (entry[3:0] == code_end) ? StDone : StPress;
        end
    end

    // Outputs are registered: decode from the next state so they change on the entry edge.
    always_comb begin
        keys_d = '0;
        for (int k = 0; k < n_keys; k++) begin
            keys_d[k] = (state_d == StPress) && ({28'd0, code_d} == 32'(k));
        end
        snr_d  = !((state_d == StPress) && (code_d == code_rst));
        busy_d = (state_d == StPress) || (state_d == StGap);
        done_d = (state_d == StDone);
    end

    assign keys        = keys_q;
    assign sys_n_reset = snr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign step_idx    = step_q;

endmodule

// File: tb/tb_uk101_autotype_seq.sv
// Self-checking bench: fixed timeline checks plus randomized start/abort against a
// cycle-countdown reference model, on an autostart and a manual-start instance.
module tb_uk101_autotype_seq;

    localparam int TD  = 4;
    localparam int GAP = 1;
    localparam int NST = 4;
    localparam logic [31:0] SCR_A = 32'hFF_0E_00_1D;
    localparam logic [31:0] SCR_B = 32'h10_01_2E_0D;
    localparam int PH_IDLE = 0, PH_PRESS = 1, PH_GAP = 2, PH_DONE = 3;

    typedef struct {
        int ph;
        int rem;
        int idx;
        int code;
        bit pend;
        bit rst;
    } mdl_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic snr_a, busy_a, done_a, snr_b, busy_b, done_b;
    logic [2:0] keys_a, keys_b;
    logic [1:0] idx_a, idx_b;
    logic [7:0] obs_a, obs_b;
    int checks = 0, errors = 0;
    mdl_t m_a, m_b;

    always #5 clk = ~clk;

    assign obs_a = {snr_a, keys_a, busy_a, done_a, idx_a};
    assign obs_b = {snr_b, keys_b, busy_b, done_b, idx_b};

    uk101_autotype_seq #(
        .tick_div(TD), .gap_ticks(GAP), .n_keys(3), .n_steps(NST),
        .script(SCR_A), .autostart(1'b1)
    ) dut_a (
        .clk(clk), .n_reset(n_reset), .start(start), .abort(abort),
        .sys_n_reset(snr_a), .keys(keys_a), .busy(busy_a), .done(done_a), .step_idx(idx_a)
    );

    uk101_autotype_seq #(
        .tick_div(TD), .gap_ticks(GAP), .n_keys(3), .n_steps(NST),
        .script(SCR_B), .autostart(1'b0)
    ) dut_b (
        .clk(clk), .n_reset(n_reset), .start(start), .abort(abort),
        .sys_n_reset(snr_b), .keys(keys_b), .busy(busy_b), .done(done_b), .step_idx(idx_b)
    );

    function automatic mdl_t mreset(bit as);
        mdl_t m;
        m.ph = PH_IDLE; m.rem = 0; m.idx = 0; m.code = 0; m.pend = as; m.rst = 1'b1;
        return m;
    endfunction

    // Each step holds for a countdown of whole clocks; no prescaler or tick counter.
    function automatic mdl_t mstep(mdl_t m, bit st, bit ab, logic [31:0] scr);
        mdl_t n;
        bit ld;
        int li;
        logic [7:0] ent;
        n = m; n.rst = 1'b0; ld = 1'b0; li = 0;
        case (m.ph)
            PH_IDLE: begin
                if (ab) n.pend = 1'b0;
                else if (st || m.pend) begin ld = 1'b1; n.pend = 1'b0; end
            end
            PH_PRESS, PH_GAP: begin
                if (ab) begin n.ph = PH_IDLE; n.idx = 0; end
                else if (m.rem > 1) n.rem = m.rem - 1;
                else if (m.ph == PH_PRESS) begin n.ph = PH_GAP; n.rem = GAP * TD; end
                else if (m.idx == NST - 1) n.ph = PH_DONE;
                else begin ld = 1'b1; li = m.idx + 1; end
            end
            default: begin
                if (ab) begin n.ph = PH_IDLE; n.idx = 0; end
                else if (st) ld = 1'b1;
            end
        endcase
        if (ld) begin
            ent = scr[8*li +: 8];
            n.idx = li;
            n.code = int'(ent[3:0]);
            if (ent[3:0] == 4'hF) n.ph = PH_DONE;
            else begin n.ph = PH_PRESS; n.rem = (int'(ent[7:4]) + 1) * TD; end
        end
        return n;
    endfunction

    function automatic logic [7:0] mexp(mdl_t m);
        logic [2:0] k;
        logic snr;
        k = '0;
        if (m.ph == PH_PRESS && m.code < 3) k[m.code] = 1'b1;
        snr = m.rst ? 1'b0 : !(m.ph == PH_PRESS && m.code == 13);
        return {snr, k, (m.ph == PH_PRESS || m.ph == PH_GAP), (m.ph == PH_DONE), 2'(m.idx)};
    endfunction

    // Instance A's documented timeline, edge e counted from reset release.
    function automatic logic [7:0] spec_trace(int e);
        logic snr, bz, dn;
        logic [2:0] k;
        logic [1:0] ix;
        snr = !(e >= 1 && e <= 8);
        k   = (e >= 13 && e <= 16) ? 3'b001 : 3'b000;
        bz  = (e <= 28);
        dn  = (e >= 29);
        ix  = (e <= 12) ? 2'd0 : (e <= 20) ? 2'd1 : (e <= 28) ? 2'd2 : 2'd3;
        return {snr, k, bz, dn, ix};
    endfunction

    task automatic tick();
        bit s, a;
        s = start; a = abort;
        @(posedge clk);
        if (n_reset) begin
            m_a = mstep(m_a, s, a, SCR_A);
            m_b = mstep(m_b, s, a, SCR_B);
        end
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0; start = 1'b0; abort = 1'b0;
        m_a = mreset(1'b1); m_b = mreset(1'b0);
        repeat (2) tick();
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_reset = 1'b0;
        tick();
        checks++;
        if (obs_a !== 8'h00) begin
            errors++; $display("FAIL reset_a: got %b want %b", obs_a, 8'h00);
        end
        checks++;
        if (obs_b !== 8'h00) begin
            errors++; $display("FAIL reset_b: got %b want %b", obs_b, 8'h00);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_power_up();
        for (int e = 1; e <= 40; e++) begin
            tick();
            checks++;
            if (obs_a !== spec_trace(e)) begin
                errors++; $display("FAIL power_up_a edge %0d: got %b want %b", e, obs_a, spec_trace(e));
            end
            checks++;
            if (obs_b !== 8'h80) begin
                errors++; $display("FAIL idle_no_autostart edge %0d: got %b want %b", e, obs_b, 8'h80);
            end
        end
    endtask

    task automatic test_restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            if (e > 1) tick();
            checks++;
            if (obs_a !== spec_trace(e)) begin
                errors++; $display("FAIL restart_a edge %0d: got %b want %b", e, obs_a, spec_trace(e));
            end
            checks++;
            if (obs_b !== mexp(m_b)) begin
                errors++; $display("FAIL start_b edge %0d: got %b want %b", e, obs_b, mexp(m_b));
            end
        end
        checks++;
        if (obs_b !== 8'b1_000_0_1_11) begin
            errors++; $display("FAIL no_end_code_done: got %b want %b", obs_b, 8'b1_000_0_1_11);
        end
    endtask

    task automatic test_abort();
        do_reset();
        repeat (14) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (obs_a !== 8'h80) begin
                errors++; $display("FAIL abort_idle cycle %0d: got %b want %b", i, obs_a, 8'h80);
            end
            tick();
        end
    endtask

    task automatic test_start_abort_same();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs_a !== 8'h80 || obs_b !== 8'h80) begin
                errors++; $display("FAIL start_abort_same cycle %0d: got %b/%b want %b", i, obs_a, obs_b, 8'h80);
            end
        end
    endtask

    task automatic test_start_in_gap();
        do_reset();
        for (int e = 1; e <= 34; e++) begin
            start = (e == 11) || (e == 18);
            tick();
            checks++;
            if (obs_a !== spec_trace(e)) begin
                errors++; $display("FAIL start_in_gap edge %0d: got %b want %b", e, obs_a, spec_trace(e));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (14) tick();
        #2;
        n_reset = 1'b0;
        m_a = mreset(1'b1); m_b = mreset(1'b0);
        #1;
        checks++;
        if (obs_a !== 8'h00) begin
            errors++; $display("FAIL async_reset: got %b want %b", obs_a, 8'h00);
        end
        repeat (2) tick();
        n_reset = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            checks++;
            if (obs_a !== spec_trace(e)) begin
                errors++; $display("FAIL replay edge %0d: got %b want %b", e, obs_a, spec_trace(e));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 11) == 0);
            abort = ($urandom_range(0, 59) == 0);
            tick();
            checks++;
            if (obs_a !== mexp(m_a)) begin
                errors++; $display("FAIL random_a cycle %0d: got %b want %b", i, obs_a, mexp(m_a));
            end
            checks++;
            if (obs_b !== mexp(m_b)) begin
                errors++; $display("FAIL random_b cycle %0d: got %b want %b", i, obs_b, mexp(m_b));
            end
        end
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_restart();
        test_abort();
        test_start_abort_same();
        test_start_in_gap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
